denoise_stream_ctrl: RTL and testbench

Streaming sequencer for the combinational NxN neighbourhood-count denoise core.
- Accepts a raster-order per-pixel colour-mask stream and builds the NxN window using line buffers and a window shift register.
- Zero-pads the window at image borders, feeds the window to one instance of the `denoise` core, and emits a registered, framed output stream.
- Latches the neighbourhood threshold per frame and flushes the pipeline at end of frame.

---
 rtl/denoise_pkg.sv | 19 +
 rtl/denoise.sv | 29 ++
 rtl/denoise_line_buf.sv | 35 +++
 rtl/denoise_stream_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_denoise_stream_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/denoise_pkg.sv
// Shared types and sizing helpers for the denoise streaming controller.
package denoise_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

    function automatic int unsigned half_of(input int unsigned n);
        return n / 2;
    endfunction

    function automatic int unsigned sum_width(input int unsigned n);
        return $clog2(n * n + 1);
    endfunction

    // Width of a coordinate counter spanning 0..extent-1.
    function automatic int unsigned coord_w(input int unsigned extent);
        return (extent > 1) ? $clog2(extent) : 1;
    endfunction

endpackage

// File: rtl/denoise.sv
// Combinational NxN neighbourhood-count core: bit c set when count of colour c >= thr.
module denoise
    import denoise_pkg::*;
#(
    parameter int unsigned N_SIZE = 5,
    parameter int unsigned COLORS = 1
) (
    input  logic [N_SIZE*N_SIZE*COLORS-1:0] window,
    input  logic [3:0]                      thr,
    output logic [COLORS-1:0]               out_pix_c
);
    localparam int unsigned SUM_W = sum_width(N_SIZE);
    localparam int unsigned CMP_W = (SUM_W > 4) ? SUM_W : 4;

    logic [SUM_W-1:0] cnt;

    always_comb begin
        out_pix_c = '0;
        cnt       = '0;
        for (int c = 0; c < int'(COLORS); c++) begin
            cnt = '0;
            for (int e = 0; e < int'(N_SIZE * N_SIZE); e++) begin
                cnt = cnt + SUM_W'(window[e*int'(COLORS) + c]);
            end
            out_pix_c[c] = (CMP_W'(cnt) >= CMP_W'(thr));
        end
    end

endmodule

// File: rtl/denoise_line_buf.sv
// One WIDTH-deep delay line of colour masks, advanced once per enabled step.
module denoise_line_buf #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned COLORS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic [COLORS-1:0] din,
    output logic [COLORS-1:0] tap
);
    logic [COLORS-1:0] mem_q [WIDTH];
    logic [COLORS-1:0] mem_d [WIDTH];

    // clr empties the line; with en the new pixel still enters at the head.
    always_comb begin
        for (int i = 0; i < int'(WIDTH); i++) mem_d[i] = clr ? '0 : mem_q[i];
        if (en) begin
            mem_d[0] = din;
            for (int i = 1; i < int'(WIDTH); i++) mem_d[i] = clr ? '0 : mem_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(WIDTH); i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) mem_q[i] <= mem_d[i];
        end
    end

    assign tap = mem_q[WIDTH-1];

endmodule

// File: rtl/denoise_stream_ctrl.sv
// Raster-stream sequencer: line buffers + window, border masking, framed output.
// Optional DENOISE_STATS_EN adds cleared_cnt (per-frame count of cleared pixels).
module denoise_stream_ctrl
    import denoise_pkg::*;
#(
    parameter int unsigned N_SIZE = 5,
    parameter int unsigned COLORS = 1,
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic [COLORS-1:0] in_pix,
    input  logic [3:0]        n_threshold,
    output logic              out_valid,
    output logic              out_sof,
    output logic              out_eof,
    output logic [COLORS-1:0] out_pix,
    output logic              frame_err
`ifdef DENOISE_STATS_EN
    ,
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0] cleared_cnt
`endif
);
    localparam int unsigned HALF      = half_of(N_SIZE);
    localparam int unsigned PIXELS    = WIDTH * HEIGHT;
    localparam int unsigned CSTART    = HALF * WIDTH + HALF;
    localparam int unsigned LAST_STEP = PIXELS + CSTART - 1;
    localparam int unsigned STEP_W    = $clog2(LAST_STEP + 2);
    localparam int unsigned XW        = coord_w(WIDTH);
    localparam int unsigned YW        = coord_w(HEIGHT);
    localparam int unsigned WIN_BITS  = N_SIZE * N_SIZE * COLORS;

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [3:0]        thr_q, thr_d;
    logic [STEP_W-1:0] step_q, step_d, cur_step;
    logic [XW-1:0]     ox_q, ox_d, cur_x;
    logic [YW-1:0]     oy_q, oy_d, cur_y;
    logic              out_valid_q, out_valid_d, out_sof_q, out_sof_d;
    logic              out_eof_q, out_eof_d, frame_err_q, frame_err_d;
    logic [COLORS-1:0] out_pix_q, out_pix_d;
    logic              accept, start, abort, step_en, cvalid;
    logic [COLORS-1:0] pix_new, core_out;
    logic [COLORS-1:0] win_q [N_SIZE][N_SIZE];
    logic [COLORS-1:0] win_d [N_SIZE][N_SIZE];
    logic [COLORS-1:0] taps   [N_SIZE-1];
    logic [COLORS-1:0] lb_din [N_SIZE-1];
    logic [WIN_BITS-1:0] win_flat;
    logic row_ok, col_ok;

    // Frame sequencing, step generation and centre tracking.
    always_comb begin
        state_d     = state_q;
        thr_d       = thr_q;
        ox_d        = ox_q;
        oy_d        = oy_q;
        accept      = in_valid & in_ready_q;
        start       = accept & in_sof & (state_q != FLUSH);
        abort       = start & (state_q == RUN);
        step_en     = (state_q == FLUSH) | (accept & ((state_q == RUN) | start));
        cur_step    = start ? '0 : step_q;
        cur_x       = start ? '0 : ox_q;
        cur_y       = start ? '0 : oy_q;
        pix_new     = (state_q == FLUSH) ? '0 : in_pix;
        cvalid      = step_en & (cur_step >= STEP_W'(CSTART));
        step_d      = step_en ? cur_step + STEP_W'(1) : step_q;
        frame_err_d = abort;
        if (start) begin
            thr_d = n_threshold;
            ox_d  = '0;
            oy_d  = '0;
        end
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (!abort && step_en && step_q == STEP_W'(PIXELS - 1)) state_d = FLUSH;
            FLUSH:   if (step_q == STEP_W'(LAST_STEP)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d != FLUSH);
        if (cvalid) begin
            if (cur_x == XW'(WIDTH - 1)) begin
                ox_d = '0;
                oy_d = (cur_y == YW'(HEIGHT - 1)) ? '0 : cur_y + YW'(1);
            end else begin
                ox_d = cur_x + XW'(1);
                oy_d = cur_y;
            end
        end
        out_valid_d = cvalid;
        out_sof_d   = cvalid && cur_x == '0 && cur_y == '0;
        out_eof_d   = cvalid && cur_x == XW'(WIDTH - 1) && cur_y == YW'(HEIGHT - 1);
    end

    // Window shift, line-buffer feed and border masking of the next window.
    always_comb begin
        for (int r = 0; r < int'(N_SIZE); r++)
            for (int c = 0; c < int'(N_SIZE); c++) win_d[r][c] = win_q[r][c];
        lb_din[0] = pix_new;
        for (int i = 1; i < int'(N_SIZE) - 1; i++) lb_din[i] = abort ? '0 : taps[i-1];
        if (step_en) begin
            for (int r = 0; r < int'(N_SIZE); r++)
                for (int c = 0; c < int'(N_SIZE) - 1; c++) win_d[r][c] = abort ? '0 : win_q[r][c+1];
            for (int r = 0; r < int'(N_SIZE) - 1; r++)
                win_d[r][N_SIZE-1] = abort ? '0 : taps[int'(N_SIZE) - 2 - r];
            win_d[N_SIZE-1][N_SIZE-1] = pix_new;
        end
        win_flat = '0;
        row_ok   = 1'b0;
        col_ok   = 1'b0;
        for (int r = 0; r < int'(N_SIZE); r++) begin
            row_ok = (int'(cur_y) + r - int'(HALF) >= 0) && (int'(cur_y) + r - int'(HALF) < int'(HEIGHT));
            for (int c = 0; c < int'(N_SIZE); c++) begin
                col_ok = (int'(cur_x) + c - int'(HALF) >= 0) && (int'(cur_x) + c - int'(HALF) < int'(WIDTH));
                win_flat[(r*int'(N_SIZE) + c)*int'(COLORS) +: COLORS] = (row_ok && col_ok) ? win_d[r][c] : '0;
            end
        end
        out_pix_d = cvalid ? core_out : '0;
    end

    for (genvar i = 0; i < int'(N_SIZE) - 1; i++) begin : g_lb
        denoise_line_buf #(.WIDTH(WIDTH), .COLORS(COLORS)) u_lb (
            .clk   (clk),
            .reset (reset),
            .en    (step_en),
            .clr   (abort),
            .din   (lb_din[i]),
            .tap   (taps[i])
        );
    end

    denoise #(.N_SIZE(N_SIZE), .COLORS(COLORS)) u_core (
        .window    (win_flat),
        .thr       (thr_q),
        .out_pix_c (core_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            thr_q       <= '0;
            step_q      <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_pix_q   <= '0;
            frame_err_q <= 1'b0;
            for (int r = 0; r < int'(N_SIZE); r++)
                for (int c = 0; c < int'(N_SIZE); c++) win_q[r][c] <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            thr_q       <= thr_d;
            step_q      <= step_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            out_pix_q   <= out_pix_d;
            frame_err_q <= frame_err_d;
            for (int r = 0; r < int'(N_SIZE); r++)
                for (int c = 0; c < int'(N_SIZE); c++) win_q[r][c] <= win_d[r][c];
        end
    end

`ifdef DENOISE_STATS_EN
    localparam int unsigned CNT_W = $clog2(PIXELS + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cleared;

    // The centre element is always inside the image when cvalid is set.
    always_comb begin
        cleared = |(win_d[HALF][HALF] & ~core_out);
        cnt_d   = cnt_q;
        if (cvalid) cnt_d = out_sof_d ? CNT_W'(cleared) : cnt_q + CNT_W'(cleared);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cleared_cnt = cnt_q;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign out_pix   = out_pix_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_denoise_stream_ctrl.sv
// Directed bench for denoise_stream_ctrl at N_SIZE=3, COLORS=1, WIDTH=4, HEIGHT=3.
module tb_denoise_stream_ctrl;
    localparam int unsigned N_SIZE = 3;
    localparam int unsigned COLORS = 1;
    localparam int unsigned WIDTH  = 4;
    localparam int unsigned HEIGHT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_sof = 1'b0;
    logic [0:0] in_pix = '0;
    logic [3:0] n_threshold = '0;
    logic       out_valid, out_sof, out_eof, frame_err;
    logic [0:0] out_pix;
`ifdef DENOISE_STATS_EN
    logic [3:0] cleared_cnt;
`endif

    always #5 clk = ~clk;

    denoise_stream_ctrl #(.N_SIZE(N_SIZE), .COLORS(COLORS), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sof      (in_sof),
        .in_pix      (in_pix),
        .n_threshold (n_threshold),
        .out_valid   (out_valid),
        .out_sof     (out_sof),
        .out_eof     (out_eof),
        .out_pix     (out_pix),
        .frame_err   (frame_err)
`ifdef DENOISE_STATS_EN
        ,
        .cleared_cnt (cleared_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int cap_n = 0;
    int err_pulses = 0;
    logic cap_pix [256];
    logic cap_sof [256];
    logic cap_eof [256];
    int   cap_cyc [256];
    int   acc_edge [12];

    always @(posedge clk) cyc <= cyc + 1;

    // Output capture, sampled on the falling edge.
    always @(negedge clk) begin
        if (out_valid) begin
            if (cap_n < 256) begin
                cap_pix[cap_n] = out_pix[0];
                cap_sof[cap_n] = out_sof;
                cap_eof[cap_n] = out_eof;
                cap_cyc[cap_n] = cyc;
            end
            cap_n = cap_n + 1;
        end
        if (frame_err) err_pulses = err_pulses + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("ready_wait", int'(in_ready), 1);
    endtask

    // Threshold is driven inverted on non-sof pixels to prove it is latched at sof.
    task automatic send_frame(input logic [11:0] img, input logic [3:0] thr, input bit stall);
        for (int i = 0; i < 12; i++) begin
            if (stall) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            in_valid    = 1'b1;
            in_sof      = (i == 0);
            in_pix[0]   = img[i];
            n_threshold = (i == 0) ? thr : ~thr;
            tick();
            acc_edge[i] = cyc;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    function automatic logic [11:0] pack_pix(input int base);
        logic [11:0] v = '0;
        for (int j = 0; j < 12; j++) v[j] = cap_pix[base + j];
        return v;
    endfunction

    task automatic check_frame(input string tag, input int base, input logic [11:0] exp);
        logic [11:0] s = '0;
        logic [11:0] e = '0;
        for (int j = 0; j < 12; j++) begin
            s[j] = cap_sof[base + j];
            e[j] = cap_eof[base + j];
        end
        chk({tag, "_count"}, cap_n - base, 12);
        chk({tag, "_pix"}, int'(pack_pix(base)), int'(exp));
        chk({tag, "_sof"}, int'(s), 12'h001);
        chk({tag, "_eof"}, int'(e), 12'h800);
    endtask

    // Output for centre j appears right after the edge of step j+5.
    task automatic check_latency(input string tag, input int base);
        int s, e;
        for (int j = 0; j < 12; j++) begin
            s = j + 5;
            e = (s <= 11) ? acc_edge[s] : acc_edge[11] + (s - 11);
            chk(tag, cap_cyc[base + j], e);
        end
    endtask

    initial begin
        int base, ebase, n;
        logic [11:0] ref_vec;

        repeat (3) tick();
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_pix", int'(out_pix), 0);
        chk("rst_frame_err", int'(frame_err), 0);
`ifdef DENOISE_STATS_EN
        chk("rst_cleared_cnt", int'(cleared_cnt), 0);
`endif
        reset = 1'b0;
        tick();

        wait_ready();
        base = cap_n;
        send_frame(12'hFFF, 4'd9, 1'b0);
        wait_ready();
        tick();
        check_frame("ones_thr9", base, 12'h060);
        check_latency("ones_thr9_lat", base);

        base = cap_n;
        send_frame(12'h040, 4'd2, 1'b0);
        wait_ready();
        tick();
        check_frame("single_thr2", base, 12'h000);

        base = cap_n;
        send_frame(12'h040, 4'd1, 1'b0);
        wait_ready();
        tick();
        check_frame("single_thr1", base, 12'hEEE);

        base = cap_n;
        send_frame(12'hC63, 4'd0, 1'b0);
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("flush_ready_low", n, 5);
        tick();
        check_frame("diag_thr0", base, 12'hFFF);

        base = cap_n;
        send_frame(12'hC63, 4'd4, 1'b0);
        wait_ready();
        tick();
        check_frame("diag_thr4", base, 12'h462);
        ref_vec = pack_pix(base);

        base = cap_n;
        send_frame(12'hC63, 4'd4, 1'b1);
        wait_ready();
        tick();
        check_frame("diag_stall", base, 12'h462);
        chk("stall_vs_plain", int'(pack_pix(base)), int'(ref_vec));
        check_latency("stall_lat", base);

        base  = cap_n;
        ebase = err_pulses;
        for (int i = 0; i < 5; i++) begin
            in_valid    = 1'b1;
            in_sof      = (i == 0);
            in_pix[0]   = 1'b1;
            n_threshold = 4'd9;
            tick();
        end
        send_frame(12'h040, 4'd1, 1'b0);
        wait_ready();
        tick();
        chk("abort_err_pulses", err_pulses - ebase, 1);
        check_frame("abort_restart", base, 12'hEEE);

        base = cap_n;
        for (int i = 0; i < 7; i++) begin
            in_valid    = 1'b1;
            in_sof      = (i == 0);
            in_pix[0]   = 1'b1;
            n_threshold = 4'd9;
            tick();
        end
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_pix", int'(out_pix), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_frame_err", int'(frame_err), 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (8) tick();
        chk("midrst_no_more_out", cap_n - base, 2);

        wait_ready();
        base = cap_n;
        send_frame(12'hFFF, 4'd9, 1'b0);
        wait_ready();
        tick();
        check_frame("post_rst_ones", base, 12'h060);
`ifdef DENOISE_STATS_EN
        chk("cleared_cnt", int'(cleared_cnt), 10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
